// File: rtl/adc_pkg.sv
// Shared definitions for the SPI ADC front end and its downstream consumers.
//   ADC_W           : native conversion width of the external ADC
//   adc_word_t      : one raw conversion word (also consumed by ADC_Data)
//   adc_spi_state_t : frame sequencer states of adc_spi_reader
//   frame_len()     : clk cycles from first START cycle through DONE
//   cs_active()     : states in which the ADC chip select is asserted
package adc_pkg;

  localparam int ADC_W = 12;

  typedef logic [ADC_W-1:0] adc_word_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    DONE,
    WAIT
  } adc_spi_state_t;

  // Setup half-period, DATA_W full sclk periods, then the single DONE cycle.
  function automatic int frame_len(input int clk_div, input int data_w);
    return clk_div * (1 + 2 * data_w) + 1;
  endfunction

  function automatic logic cs_active(input adc_spi_state_t s);
    return (s == START) || (s == SHIFT);
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// Serial clock generator for the SPI ADC reader.
//   clk, reset : system clock, asynchronous active-high reset
//   en         : run the divider; low forces sclk low and clears the divider
//   sclk       : registered serial clock, CLK_DIV clk cycles per half-period
//   rise_tick  : high on the cycle whose closing clk edge drives sclk 0->1
//   fall_tick  : high on the cycle whose closing clk edge drives sclk 1->0
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       half_done;

  // The ticks look ahead one cycle so the owner can act on the same edge
  // that moves sclk (sampling MISO exactly as sclk rises).
  assign half_done = en && (div_cnt == DIV_LAST);
  assign rise_tick = half_done && !sclk;
  assign fall_tick = half_done && sclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI front end for the external 12-bit ADC. Runs one conversion frame every
// SAMPLE_PERIOD clk cycles while enabled, shifting the result in MSB-first.
//   clk, reset : system clock, asynchronous active-high reset
//   enable     : level; 1 keeps periodic conversions running
//   adc_cs_n   : ADC chip select, active low
//   adc_sclk   : ADC serial clock, idles low
//   adc_miso   : ADC serial data, changed by the ADC on sclk falling edges
//   ADC_raw    : last completed conversion, held between frames
//   raw_valid  : one-cycle pulse when ADC_raw updates
//   busy       : high while cs_n is low and during the DONE cycle
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int DATA_W        = ADC_W,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_miso,
  output logic [DATA_W-1:0] ADC_raw,
  output logic              raw_valid,
  output logic              busy
);

  localparam int FRAME_LEN = frame_len(CLK_DIV, DATA_W);
  localparam int PW        = $clog2(SAMPLE_PERIOD);
  localparam int BW        = $clog2(DATA_W + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] SETUP_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("adc_spi_reader: CLK_DIV must be within 1..255");
    end
    if (SAMPLE_PERIOD < FRAME_LEN + 1) begin : g_bad_period
      $error("adc_spi_reader: SAMPLE_PERIOD must be at least FRAME_LEN+1");
    end
  endgenerate

  adc_spi_state_t    state;
  adc_spi_state_t    nxt;
  logic [PW-1:0]     period_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              sclk_en;
  logic              rise_tick;
  logic              fall_tick;

  assign sclk_en = (state == SHIFT);

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (sclk_en),
    .sclk     (adc_sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // The period counter doubles as the START setup timer: it is 0 on the
  // first START cycle of every frame, so START lasts exactly CLK_DIV cycles.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (enable) nxt = START;
      START:   if (period_cnt == SETUP_LAST) nxt = SHIFT;
      SHIFT:   if (fall_tick && (bit_cnt == BIT_LAST)) nxt = DONE;
      DONE:    nxt = WAIT;
      WAIT:    if (period_cnt == PERIOD_LAST) nxt = enable ? START : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Period counter: held at 0 in IDLE, free-running and wrapping otherwise,
  // so frame starts stay exactly SAMPLE_PERIOD apart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (state == IDLE || period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (state != SHIFT) begin
      bit_cnt <= '0;
    end else if (fall_tick) begin
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  // MISO is sampled on the edge that raises sclk, mid-way through the data
  // eye since the ADC only changes it on falling edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (rise_tick) begin
      shift_reg <= {shift_reg[DATA_W-2:0], adc_miso};
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_cs_n  <= 1'b1;
      busy      <= 1'b0;
      raw_valid <= 1'b0;
      ADC_raw   <= '0;
    end else begin
      adc_cs_n  <= !cs_active(nxt);
      busy      <= cs_active(nxt) || (nxt == DONE);
      raw_valid <= (nxt == DONE);
      if (nxt == DONE) begin
        ADC_raw <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: a behavioural ADC drives MISO from a
// per-frame word table and every frame is compared cycle by cycle against
// the timing derived from CLK_DIV, DATA_W and SAMPLE_PERIOD.
module tb_adc_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, cs_a, sclk_a, miso_a, valid_a, busy_a;
  logic [11:0] raw_a;
  logic        rst_b, en_b, cs_b, sclk_b, miso_b, valid_b, busy_b;
  logic [11:0] raw_b;

  adc_spi_reader #(.CLK_DIV(4), .DATA_W(12), .SAMPLE_PERIOD(5000)) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .adc_cs_n(cs_a), .adc_sclk(sclk_a),
    .adc_miso(miso_a), .ADC_raw(raw_a), .raw_valid(valid_a), .busy(busy_a)
  );

  adc_spi_reader #(.CLK_DIV(1), .DATA_W(12), .SAMPLE_PERIOD(27)) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .adc_cs_n(cs_b), .adc_sclk(sclk_b),
    .adc_miso(miso_b), .ADC_raw(raw_b), .raw_valid(valid_b), .busy(busy_b)
  );

  // ADC models: word latched when cs_n falls, MSB presented first, next bit
  // presented after every sclk falling edge.
  logic [11:0] word_a = '0, cur_a = '0;
  int          bidx_a = 0;
  logic        sq_a = 1'b0, loaded_a = 1'b0;
  always @(cs_a, sclk_a) begin
    if (cs_a) begin
      bidx_a = 0; loaded_a = 1'b0;
    end else if (!loaded_a) begin
      cur_a = word_a; loaded_a = 1'b1; bidx_a = 0;
    end else if (!sclk_a && sq_a) begin
      bidx_a++;
    end
    sq_a = sclk_a;
  end
  assign miso_a = (bidx_a < 12) ? cur_a[11 - bidx_a] : 1'b0;

  logic [11:0] word_b = '0, cur_b = '0;
  int          bidx_b = 0;
  logic        sq_b = 1'b0, loaded_b = 1'b0;
  always @(cs_b, sclk_b) begin
    if (cs_b) begin
      bidx_b = 0; loaded_b = 1'b0;
    end else if (!loaded_b) begin
      cur_b = word_b; loaded_b = 1'b1; bidx_b = 0;
    end else if (!sclk_b && sq_b) begin
      bidx_b++;
    end
    sq_b = sclk_b;
  end
  assign miso_b = (bidx_b < 12) ? cur_b[11 - bidx_b] : 1'b0;

  typedef struct {
    logic [11:0] word;     // value the ADC model returns for this frame
    logic [11:0] exp_raw;  // ADC_raw required at the raw_valid pulse
    int          off_from; // enable held low for frame cycles [off_from, off_to)
    int          off_to;
  } frame_vec_t;

  frame_vec_t tbl[9];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Called on a negedge with the DUT idle; the next posedge is edge 0.
  task automatic run_frames(input bit sel, input int d, input int sp,
                            input int first, input int last);
    int s, se, vc, abs_prev, bad_cs, bad_sc, bad_bz, rises, nval, vat;
    logic [11:0] vraw, raw;
    logic sc_prev, cs, sc, rv, bz, en_next;
    s  = 1 + d;
    se = s + 2 * d * 12 - 1;
    vc = se + 1;
    abs_prev = -1;
    if (sel) begin word_b = tbl[first].word; en_b = 1'b1; end
    else     begin word_a = tbl[first].word; en_a = 1'b1; end
    for (int k = first; k <= last; k++) begin
      bad_cs = 0; bad_sc = 0; bad_bz = 0; rises = 0; nval = 0; vat = -1;
      vraw = '0; sc_prev = 1'b0;
      for (int l = 1; l <= sp; l++) begin
        @(negedge clk);
        if (sel) begin cs = cs_b; sc = sclk_b; rv = valid_b; bz = busy_b; raw = raw_b; end
        else     begin cs = cs_a; sc = sclk_a; rv = valid_a; bz = busy_a; raw = raw_a; end
        if (cs !== (l > se)) bad_cs++;
        if (sc !== ((l >= s) && (l <= se) && ((((l - s) / d) % 2) == 1))) bad_sc++;
        if (bz !== (l <= vc)) bad_bz++;
        if (sc && !sc_prev) rises++;
        sc_prev = sc;
        if (rv === 1'b1) begin nval++; vat = l; vraw = raw; end
        en_next = !((l >= tbl[k].off_from) && (l < tbl[k].off_to));
        if (sel) en_b = en_next; else en_a = en_next;
        if (l == sp && k < last) begin
          if (sel) word_b = tbl[k + 1].word; else word_a = tbl[k + 1].word;
        end
      end
      check($sformatf("frame%0d cs_n bad cycles", k), bad_cs, 0);
      check($sformatf("frame%0d sclk bad cycles", k), bad_sc, 0);
      check($sformatf("frame%0d busy bad cycles", k), bad_bz, 0);
      check($sformatf("frame%0d sclk rising edges", k), rises, 12);
      check($sformatf("frame%0d raw_valid pulses", k), nval, 1);
      check($sformatf("frame%0d raw_valid cycle", k), vat, vc);
      check($sformatf("frame%0d ADC_raw", k), int'(vraw), int'(tbl[k].exp_raw));
      if (abs_prev >= 0)
        check($sformatf("frame%0d raw_valid spacing", k), (k - first) * sp + vat - abs_prev, sp);
      abs_prev = (k - first) * sp + vat;
    end
  endtask

  initial begin
    int bad, nv;
    tbl[0] = '{12'hA5C, 12'hA5C, 0, 0};
    tbl[1] = '{12'h000, 12'h000, 200, 3000};   // enable wiggles inside WAIT
    tbl[2] = '{12'hFFF, 12'hFFF, 0, 0};
    tbl[3] = '{12'h801, 12'h801, 0, 0};
    tbl[4] = '{12'h6B9, 12'h6B9, 30, 99999};   // enable dropped at cycle 30
    tbl[5] = '{12'h3C3, 12'h3C3, 1, 99999};    // first frame after reset
    tbl[6] = '{12'h5A5, 12'h5A5, 0, 0};
    tbl[7] = '{12'h5A5, 12'h5A5, 0, 0};
    tbl[8] = '{12'h5A5, 12'h5A5, 0, 0};

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cs_n", cs_a, 1);
    check("reset sclk", sclk_a, 0);
    check("reset ADC_raw", raw_a, 0);
    check("reset raw_valid", valid_a, 0);
    check("reset busy", busy_a, 0);
    check("reset cs_n b", cs_b, 1);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);

    run_frames(1'b0, 4, 5000, 0, 4);

    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (cs_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== 1'b0) bad++;
    end
    check("idle after enable drop", bad, 0);
    check("ADC_raw held after drop", raw_a, 12'h6B9);

    // Abort a frame in mid-SHIFT at cycle 50, while sclk is high.
    word_a = 12'h3C3; en_a = 1'b1; nv = 0;
    for (int l = 1; l <= 50; l++) begin
      @(negedge clk);
      if (valid_a) nv++;
    end
    check("cycle50 cs_n before reset", cs_a, 0);
    check("cycle50 sclk before reset", sclk_a, 1);
    rst_a = 1'b1;
    #1;
    check("abort cs_n", cs_a, 1);
    check("abort sclk", sclk_a, 0);
    check("abort ADC_raw", raw_a, 0);
    check("abort raw_valid", valid_a, 0);
    check("abort busy", busy_a, 0);
    repeat (3) begin
      @(negedge clk);
      if (valid_a) nv++;
    end
    check("no raw_valid for aborted frame", nv, 0);
    rst_a = 1'b0;
    run_frames(1'b0, 4, 5000, 5, 5);

    // Enable low straight out of reset.
    rst_a = 1'b1; en_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (cs_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== 1'b0) bad++;
    end
    check("quiet while disabled", bad, 0);
    check("ADC_raw while disabled", raw_a, 0);

    // Minimum sample period: back-to-back frames at CLK_DIV = 1.
    rst_b = 1'b0;
    @(negedge clk);
    run_frames(1'b1, 1, 27, 6, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Serial front end that drives the external 12-bit SPI ADC.
- Generates chip-select and serial clock, shifts in one conversion MSB-first, and presents it as a parallel ADC_raw word with a one-cycle valid strobe.
- Sits upstream of ADC_Data, which consumes ADC_raw for averaging and voltage/distance conversion.
- Runs conversions at a fixed sample rate while enabled.

Parameters:
- CLK_DIV, 4: clk cycles per adc_sclk half-period (legal range 1..255).
- DATA_W, 12: bits per conversion.
- SAMPLE_PERIOD, 5000: clk cycles from one frame start to the next. Must be >= FRAME_LEN+1; an elaboration-time assertion checks this.
- Derived: FRAME_LEN = CLK_DIV*(1+2*DATA_W)+1, which is 101 at the defaults.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = run periodic conversions
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock; idles low
- adc_miso  in  1  ADC serial data out; ADC changes it on sclk falling edges
- ADC_raw  out  DATA_W  last completed conversion
- raw_valid  out  1  one-cycle pulse when ADC_raw updates
- busy  out  1  high while cs_n is low or in DONE

Behaviour:
- Reset values (asynchronous, all outputs immediate):
  - state = IDLE
  - adc_cs_n = 1, adc_sclk = 0
  - ADC_raw = 0, raw_valid = 0, busy = 0
  - shift register, bit counter, divider counter and period counter = 0
- All outputs are registered; no combinational path from adc_miso or enable to any output.
- State machine:
  - IDLE: cs_n = 1, sclk = 0. Enter START on the cycle after enable is sampled 1. Period counter is cleared.
  - START: cs_n = 0, sclk = 0, held for CLK_DIV cycles (setup before the first edge).
  - SHIFT: DATA_W bit periods. Each bit period is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - On the clk edge that drives sclk 0->1, adc_miso is registered into shift_reg LSB, with the shift left.
    - The first bit captured is the MSB.
    - The bit counter counts 0..DATA_W-1. After the last high half, go to DONE with sclk = 0.
  - DONE: exactly 1 cycle. cs_n = 1, ADC_raw <= shift_reg, raw_valid = 1. Then go to WAIT.
  - WAIT: cs_n = 1, sclk = 0.
    - When the period counter reaches SAMPLE_PERIOD-1, go to START if enable = 1, else IDLE.
    - The period counter runs from the first START cycle and wraps to 0 at SAMPLE_PERIOD-1.
- Timing at the defaults (edge 0 = enable sampled 1 in IDLE):
  - START occupies cycles 1-4.
  - SHIFT occupies cycles 5-100; sclk rises at cycles 9, 17, ..., 97.
  - DONE is cycle 101.
  - The next START is cycle 1+SAMPLE_PERIOD.
- Enable deasserted mid-frame: the current frame completes, including DONE/raw_valid. Then go to IDLE at the end of WAIT, not early.
- Enable toggling inside WAIT: only the value at the period boundary matters.
- Reset mid-frame: abort immediately to reset values. No raw_valid for the partial frame. ADC_raw returns to 0.
- ADC_raw holds its value between frames. It changes only in DONE or on reset.
- Sample-rate jitter: none. Frame starts are exactly SAMPLE_PERIOD apart while enable stays 1.

Decomposition:
- Shared package adc_pkg:
  - ADC_W = 12
  - typedef logic [ADC_W-1:0] adc_word_t, also used by ADC_Data
  - enum adc_spi_state_t {IDLE, START, SHIFT, DONE, WAIT}
- One natural sub-module: sclk_gen.
  - Divider counter plus sclk toggle.
  - Outputs rise_tick and fall_tick, each asserted for the single cycle on which sclk changes.
  - Enabled only in SHIFT.
- The FSM, shift register and period counter stay in adc_spi_reader.

Test Plan:
- Single frame: ADC model returns 12'hA5C, enable = 1 at edge 0.
  - Expect cs_n low for cycles 1-100 and exactly 12 sclk rising edges.
  - Expect raw_valid high only at cycle 101, with ADC_raw = 12'hA5C.
- Data extremes: successive frames return 12'h000, 12'hFFF, 12'h801.
  - Expect ADC_raw to match each value in turn.
  - Expect raw_valid pulses exactly SAMPLE_PERIOD cycles apart.
  - Expect no bit slip; MSB first is confirmed by 12'h801.
- Reset at cycle 50 mid-SHIFT, with a frame value of 12'h3C3:
  - Expect cs_n = 1, sclk = 0, ADC_raw = 0 within the same cycle.
  - Expect no raw_valid.
  - After reset release with enable = 1, the first frame completes normally.
- Enable dropped at cycle 30:
  - Expect the frame to finish with raw_valid at cycle 101.
  - Expect no further cs_n assertion; busy = 0 after DONE.
- CLK_DIV = 1, SAMPLE_PERIOD = 27 (minimum, FRAME_LEN = 26), value 12'h5A5:
  - Expect back-to-back frames with one idle cs_n-high cycle between them.
  - Expect ADC_raw = 12'h5A5 every frame.
- Enable = 0 from reset:
  - Expect cs_n and sclk static at 1/0, raw_valid never asserted, busy = 0 for 10000 cycles.
